// File: rtl/fetch_unit.sv
// Instruction fetch stage for the 20-bit ISA: program counter, IF/ID register,
// stall/branch-redirect handling and a start/halt run-control FSM.
module fetch_unit #(
  parameter int unsigned PC_W    = 10,
  parameter logic [4:0]  HALT_OP = 5'd31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [19:0]     imem_data,
  output logic [4:0]      if_op,
  output logic [19:0]     if_inst,
  output logic [PC_W-1:0] if_pc,
  output logic            if_valid,
  output logic            done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   if_pc_q, if_pc_d;
  logic [19:0]       if_inst_q, if_inst_d;
  logic              if_valid_q, if_valid_d;
  logic              done_q, done_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;
    done_d     = done_q;

    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d    = S_RUN;
          pc_d       = '0;
          if_valid_d = 1'b0;
          done_d     = 1'b0;
        end else if (!stall) begin
          // the halt word stays visible while downstream is stalled
          if_valid_d = 1'b0;
        end
      end
      S_RUN: begin
        if (br_taken) begin
          pc_d       = br_target;
          if_valid_d = 1'b0;
        end else if (!stall) begin
          if_inst_d  = imem_data;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          if (imem_data[19:15] == HALT_OP) begin
            state_d = S_HALT;
            done_d  = 1'b1;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      if_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
      done_q     <= done_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_inst   = if_inst_q;
  assign if_op     = if_inst_q[19:15];
  assign if_pc     = if_pc_q;
  assign if_valid  = if_valid_q;
  assign done      = done_q;

endmodule
